// File: rtl/sobel_sequencer_if.sv
// Command/status bundle between the Sobel frame sequencer and its address
// generator, frame memory and gradient unit. The sequencer takes the master side.
interface sobel_sequencer_if;
  // status returned to the sequencer
  logic load_done;
  logic move_done;
  logic all_done;
  logic rdata_valid;
  logic calc_done;
  // commands and strobes issued by the sequencer
  logic load_initial;
  logic start_9_read;
  logic start_i_read;
  logic start_write;
  logic start_move;
  logic mem_re;
  logic mem_we;
  logic calc_start;

  modport master (
    input  load_done, move_done, all_done, rdata_valid, calc_done,
    output load_initial, start_9_read, start_i_read, start_write, start_move,
    output mem_re, mem_we, calc_start
  );

  modport slave (
    output load_done, move_done, all_done, rdata_valid, calc_done,
    input  load_initial, start_9_read, start_i_read, start_write, start_move,
    input  mem_re, mem_we, calc_start
  );
endinterface

// File: rtl/sobel_sequencer.sv
// Frame sequencer for a 3x3 Sobel engine: fills the first window, then loops
// calc -> write -> move -> step-read until the address generator reports the
// last pixel. Every output is a register computed from the next state (Moore).
module sobel_sequencer #(
  parameter int FIRST_READS = 9,
  parameter int STEP_READS  = 3
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                start,
  input  logic                abort,
  sobel_sequencer_if.master   bus,
  output logic                busy,
  output logic                frame_done,
  output logic [23:0]         pix_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READ9 = 3'd2,
    CALC  = 3'd3,
    WRITE = 3'd4,
    MOVE  = 3'd5,
    READ3 = 3'd6,
    DONE  = 3'd7
  } state_t;

  // Counter value seen on the cycle that the final read of a phase returns.
  localparam logic [3:0] FIRST_LAST = 4'(FIRST_READS - 1);
  localparam logic [3:0] STEP_LAST  = 4'(STEP_READS - 1);

  state_t      state, state_d;
  logic [3:0]  rd_cnt, rd_cnt_d;
  logic [23:0] pix_d;

  // registered outputs and their next values
  logic load_initial_q, start_9_read_q, start_i_read_q, start_write_q, start_move_q;
  logic mem_re_q, mem_we_q, calc_start_q, busy_q, frame_done_q;
  logic load_initial_d, start_9_read_d, start_i_read_d, start_write_d, start_move_d;
  logic mem_re_d, mem_we_d, calc_start_d, busy_d, frame_done_d;

  // A read returns only while waiting; mem_re_q high marks the issue cycle.
  logic rd_ret;
  logic entering;

  assign rd_ret   = bus.rdata_valid && !mem_re_q;
  assign entering = (state_d != state);

  // State, read counter, pixel counter and all output registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state          <= IDLE;
      rd_cnt         <= 4'd0;
      pix_count      <= 24'd0;
      load_initial_q <= 1'b0;
      start_9_read_q <= 1'b0;
      start_i_read_q <= 1'b0;
      start_write_q  <= 1'b0;
      start_move_q   <= 1'b0;
      mem_re_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      calc_start_q   <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state          <= state_d;
      rd_cnt         <= rd_cnt_d;
      pix_count      <= pix_d;
      load_initial_q <= load_initial_d;
      start_9_read_q <= start_9_read_d;
      start_i_read_q <= start_i_read_d;
      start_write_q  <= start_write_d;
      start_move_q   <= start_move_d;
      mem_re_q       <= mem_re_d;
      mem_we_q       <= mem_we_d;
      calc_start_q   <= calc_start_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
    end
  end

  // Next state, read counter and pixel counter; abort overrides everything.
  always_comb begin
    state_d  = state;
    rd_cnt_d = rd_cnt;
    pix_d    = pix_count;
    if (abort) begin
      state_d  = IDLE;
      rd_cnt_d = 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_d = LOAD;
            pix_d   = 24'd0;
          end
        end
        LOAD: begin
          if (bus.load_done) state_d = READ9;
        end
        READ9: begin
          if (rd_ret) begin
            if (rd_cnt == FIRST_LAST) begin
              state_d  = CALC;
              rd_cnt_d = 4'd0;
            end else begin
              rd_cnt_d = rd_cnt + 4'd1;
            end
          end
        end
        CALC: begin
          // the pixel count advances together with the write strobe
          if (bus.calc_done) begin
            state_d = WRITE;
            pix_d   = pix_count + 24'd1;
          end
        end
        WRITE: state_d = MOVE;
        MOVE: begin
          // the generator answers only after the move command cycle
          if (!start_move_q) begin
            if (bus.all_done)       state_d = DONE;
            else if (bus.move_done) state_d = READ3;
          end
        end
        READ3: begin
          if (rd_ret) begin
            if (rd_cnt == STEP_LAST) begin
              state_d  = CALC;
              rd_cnt_d = 4'd0;
            end else begin
              rd_cnt_d = rd_cnt + 4'd1;
            end
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output values for the next cycle, decoded from the next state.
  always_comb begin
    logic rd_next;
    rd_next        = (state_d == READ9) || (state_d == READ3);
    mem_re_d       = rd_next && (entering || rd_ret);
    start_9_read_d = mem_re_d && (state_d == READ9);
    start_i_read_d = mem_re_d && (state_d == READ3);
    load_initial_d = (state_d == LOAD) && entering;
    calc_start_d   = (state_d == CALC) && entering;
    start_move_d   = (state_d == MOVE) && entering;
    start_write_d  = (state_d == WRITE);
    mem_we_d       = (state_d == WRITE);
    frame_done_d   = (state_d == DONE);
    busy_d         = (state_d != IDLE);
  end

  assign bus.load_initial = load_initial_q;
  assign bus.start_9_read = start_9_read_q;
  assign bus.start_i_read = start_i_read_q;
  assign bus.start_write  = start_write_q;
  assign bus.start_move   = start_move_q;
  assign bus.mem_re       = mem_re_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.calc_start   = calc_start_q;
  assign busy             = busy_q;
  assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_sobel_sequencer.sv
// Directed bench for sobel_sequencer: a small responder plays the address
// generator / memory / gradient unit one cycle after each command.
module tb_sobel_sequencer;

  logic        clk;
  logic        n_reset;
  logic        start;
  logic        abort;
  logic        busy;
  logic        frame_done;
  logic [23:0] pix_count;

  sobel_sequencer_if bus ();

  sobel_sequencer #(.FIRST_READS(9), .STEP_READS(3)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .start      (start),
    .abort      (abort),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .pix_count  (pix_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] cmd_vec;
  assign cmd_vec = {bus.load_initial, bus.start_9_read, bus.start_i_read, bus.start_write,
                    bus.start_move, bus.mem_re, bus.mem_we, bus.calc_start};

  int checks = 0;
  int errors = 0;

  // responder controls
  logic auto_load, auto_read, auto_calc, auto_move, both_move, hold_valid;
  int   frame_pixels;
  logic p_load, p_read, p_calc, p_move;
  int   n_load, n9, ni, nwe, nmv, ncs, nfd, nmulti, nmvdone;

  task automatic clear_counts();
    n_load = 0; n9 = 0; ni = 0; nwe = 0; nmv = 0; ncs = 0; nfd = 0; nmulti = 0; nmvdone = 0;
  endtask

  task automatic clear_ctrl();
    auto_load = 0; auto_read = 0; auto_calc = 0; auto_move = 0; both_move = 0; hold_valid = 0;
    p_load = 0; p_read = 0; p_calc = 0; p_move = 0;
  endtask

  // Advance one cycle, sample outputs, count strobes, drive responses.
  task automatic cycle();
    @(posedge clk); #1;
    start = 0; abort = 0;
    bus.load_done   = auto_load & p_load;
    bus.rdata_valid = hold_valid | (auto_read & p_read);
    bus.calc_done   = auto_calc & p_calc;
    bus.move_done   = 0;
    bus.all_done    = 0;
    if (auto_move && p_move) begin
      if (nwe >= frame_pixels) begin
        bus.all_done = 1;
        if (both_move) bus.move_done = 1;
      end else begin
        bus.move_done = 1;
        nmvdone++;
      end
    end
    p_load = bus.load_initial; p_read = bus.mem_re; p_calc = bus.calc_start; p_move = bus.start_move;
    n_load += int'(bus.load_initial);
    n9     += int'(bus.start_9_read);
    ni     += int'(bus.start_i_read);
    nwe    += int'(bus.mem_we);
    nmv    += int'(bus.start_move);
    ncs    += int'(bus.calc_start);
    nfd    += int'(frame_done);
    if ($countones({bus.load_initial, bus.start_9_read, bus.start_i_read,
                    bus.start_write, bus.start_move}) > 1) nmulti++;
  endtask

  task automatic do_reset();
    n_reset = 0;
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1;
    start = 0; abort = 0;
    bus.load_done = 0; bus.move_done = 0; bus.all_done = 0; bus.rdata_valid = 0; bus.calc_done = 0;
    clear_ctrl();
    clear_counts();
    frame_pixels = 9;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (cmd_vec !== 8'h00) begin errors++; $display("FAIL reset_cmds got %h want 00", cmd_vec); end
    checks++; if (pix_count !== 24'd0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_pix got %0d/%b want 0/0", pix_count, frame_done); end
    start = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold_start got busy %b want 0", busy); end
    start = 0;
    n_reset = 1;
    cycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_idle got busy %b want 0", busy); end
  endtask

  task automatic test_start_timing();
    clear_ctrl(); clear_counts();
    start = 1;                       // cycle 0
    cycle();                         // cycle 1
    checks++; if (bus.load_initial !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL c1_load_initial got %b busy %b want 1 1", bus.load_initial, busy); end
    checks++; if (pix_count !== 24'd0) begin errors++; $display("FAIL c1_pix got %0d want 0", pix_count); end
    cycle();                         // cycle 2
    checks++; if (bus.load_initial !== 1'b0 || bus.mem_re !== 1'b0) begin
      errors++; $display("FAIL c2_quiet got li %b re %b want 0 0", bus.load_initial, bus.mem_re); end
    cycle();                         // cycle 3
    bus.load_done = 1;
    checks++; if (bus.mem_re !== 1'b0) begin errors++; $display("FAIL c3_no_read got %b want 0", bus.mem_re); end
    clear_counts();
    cycle();                         // cycle 4
    checks++; if (bus.mem_re !== 1'b1 || bus.start_9_read !== 1'b1) begin
      errors++; $display("FAIL c4_first_read got re %b s9 %b want 1 1", bus.mem_re, bus.start_9_read); end
  endtask

  task automatic test_first_pixel();
    auto_read = 1; auto_calc = 1;
    for (int i = 0; i < 200 && bus.mem_we !== 1'b1; i++) cycle();
    checks++; if (bus.mem_we !== 1'b1 || bus.start_write !== 1'b1) begin
      errors++; $display("FAIL first_write got we %b sw %b want 1 1", bus.mem_we, bus.start_write); end
    checks++; if (n9 !== 9) begin errors++; $display("FAIL read9_count got %0d want 9", n9); end
    checks++; if (ncs !== 1) begin errors++; $display("FAIL calc_start_count got %0d want 1", ncs); end
    checks++; if (nmulti !== 0) begin errors++; $display("FAIL one_hot_cmds got %0d want 0", nmulti); end
    cycle();
    checks++; if (pix_count !== 24'd1 || bus.start_move !== 1'b1 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL after_write got pix %0d mv %b we %b want 1 1 0",
                         pix_count, bus.start_move, bus.mem_we); end
  endtask

  task automatic test_valid_ignored();
    do_reset();
    hold_valid = 1; auto_load = 1;
    start = 1;
    for (int i = 0; i < 300 && bus.calc_start !== 1'b1; i++) cycle();
    checks++; if (bus.calc_start !== 1'b1) begin errors++; $display("FAIL held_valid_calc got %b want 1", bus.calc_start); end
    checks++; if (n9 !== 9) begin errors++; $display("FAIL held_valid_reads got %0d want 9", n9); end
    hold_valid = 0;
    abort = 1;
    cycle();
    checks++; if (busy !== 1'b0 || cmd_vec !== 8'h00) begin
      errors++; $display("FAIL abort_calc got busy %b cmds %h want 0 00", busy, cmd_vec); end
  endtask

  task automatic test_full_frame();
    do_reset();
    auto_load = 1; auto_read = 1; auto_calc = 1; auto_move = 1; frame_pixels = 9;
    start = 1;
    for (int i = 0; i < 3000 && frame_done !== 1'b1; i++) cycle();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL frame_done_seen got %b want 1", frame_done); end
    checks++; if (n9 !== 9) begin errors++; $display("FAIL frame_read9 got %0d want 9", n9); end
    checks++; if (ni !== 24) begin errors++; $display("FAIL frame_read3 got %0d want 24", ni); end
    checks++; if (nmvdone !== 8) begin errors++; $display("FAIL frame_steps got %0d want 8", nmvdone); end
    checks++; if (nwe !== 9 || pix_count !== 24'd9) begin
      errors++; $display("FAIL frame_writes got we %0d pix %0d want 9 9", nwe, pix_count); end
    checks++; if (nmulti !== 0) begin errors++; $display("FAIL frame_one_hot got %0d want 0", nmulti); end
    cycle();
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL frame_idle got busy %b fd %b want 0 0", busy, frame_done); end
    repeat (3) cycle();
    checks++; if (nfd !== 1 || pix_count !== 24'd9) begin
      errors++; $display("FAIL frame_hold got fd %0d pix %0d want 1 9", nfd, pix_count); end
  endtask

  task automatic test_both_move();
    do_reset();
    auto_load = 1; auto_read = 1; auto_calc = 1; auto_move = 1; both_move = 1; frame_pixels = 1;
    start = 1;
    for (int i = 0; i < 500 && frame_done !== 1'b1; i++) cycle();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL both_done got %b want 1", frame_done); end
    checks++; if (ni !== 0) begin errors++; $display("FAIL both_no_step got %0d want 0", ni); end
    checks++; if (pix_count !== 24'd1) begin errors++; $display("FAIL both_pix got %0d want 1", pix_count); end
  endtask

  task automatic test_abort_read3();
    do_reset();
    auto_load = 1; auto_read = 1; auto_calc = 1; auto_move = 1; frame_pixels = 9;
    start = 1;
    for (int i = 0; i < 500 && ni < 2; i++) cycle();
    checks++; if (ni !== 2) begin errors++; $display("FAIL abort_reach got %0d want 2", ni); end
    cycle();                         // wait phase, second step read returning
    abort = 1;
    cycle();
    checks++; if (busy !== 1'b0 || cmd_vec !== 8'h00) begin
      errors++; $display("FAIL abort_idle got busy %b cmds %h want 0 00", busy, cmd_vec); end
    checks++; if (pix_count !== 24'(nwe)) begin
      errors++; $display("FAIL abort_pix_kept got %0d want %0d", pix_count, nwe); end
    clear_counts();
    repeat (6) cycle();
    checks++; if ((n_load + n9 + ni + nwe + nmv + ncs) !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_quiet got strobes %0d busy %b want 0 0",
                         n_load + n9 + ni + nwe + nmv + ncs, busy); end
    start = 1;
    cycle();
    checks++; if (bus.load_initial !== 1'b1 || pix_count !== 24'd0) begin
      errors++; $display("FAIL restart got li %b pix %0d want 1 0", bus.load_initial, pix_count); end
  endtask

  task automatic test_reset_mid_calc();
    do_reset();
    auto_load = 1; auto_read = 1; auto_move = 1;
    start = 1;
    for (int i = 0; i < 300 && bus.calc_start !== 1'b1; i++) cycle();
    checks++; if (bus.calc_start !== 1'b1) begin errors++; $display("FAIL mid_calc_reach got %b want 1", bus.calc_start); end
    #2;
    n_reset = 0;
    #1;
    checks++; if (busy !== 1'b0 || cmd_vec !== 8'h00 || frame_done !== 1'b0) begin
      errors++; $display("FAIL async_reset got busy %b cmds %h fd %b want 0 00 0", busy, cmd_vec, frame_done); end
    @(posedge clk); #1;
    n_reset = 1;
    clear_ctrl();
    for (int i = 0; i < 3; i++) begin
      cycle();
      bus.calc_done = 1;
      checks++; if (busy !== 1'b0 || bus.mem_we !== 1'b0) begin
        errors++; $display("FAIL post_reset_calc got busy %b we %b want 0 0", busy, bus.mem_we); end
    end
  endtask

  task automatic test_abort_start_priority();
    do_reset();
    start = 1; abort = 1;
    cycle();
    checks++; if (busy !== 1'b0 || bus.load_initial !== 1'b0) begin
      errors++; $display("FAIL abort_over_start got busy %b li %b want 0 0", busy, bus.load_initial); end
  endtask

  initial begin
    n_reset = 0; start = 0; abort = 0;
    bus.load_done = 0; bus.move_done = 0; bus.all_done = 0; bus.rdata_valid = 0; bus.calc_done = 0;
    frame_pixels = 9;
    clear_ctrl();
    clear_counts();
    test_reset();
    test_start_timing();
    test_first_pixel();
    test_valid_ignored();
    test_full_frame();
    test_both_move();
    test_abort_read3();
    test_reset_mid_calc();
    test_abort_start_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
